// File: rtl/regfile_scoreboard_pkg.sv
// Shared processor definitions for the register file and its scoreboard.
package regfile_scoreboard_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned ADDR_WIDTH_DEF = 5;

  typedef logic [ADDR_WIDTH_DEF-1:0] reg_idx_t;
  typedef logic [DATA_WIDTH_DEF-1:0] word_t;

  localparam reg_idx_t ZERO_IDX = '0;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: index decode, zero/out-of-range masking,
// same-cycle write bypass and busy masking by the forwarded write.
module regfile_read_port
  import regfile_scoreboard_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned NUM_REGS   = 2**ADDR_WIDTH,
  parameter bit          ZERO_REG   = 1'b1
) (
  input  logic [ADDR_WIDTH-1:0]                rd_idx,
  input  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs,
  input  logic [NUM_REGS-1:0]                  busy,
  input  logic                                 wr_valid,
  input  logic [ADDR_WIDTH-1:0]                wr_idx,
  input  logic [DATA_WIDTH-1:0]                wr_data,
  output logic [DATA_WIDTH-1:0]                rd_data,
  output logic                                 rd_busy
);

  logic in_range;
  logic readable;
  logic fwd;

  if (NUM_REGS >= 2**ADDR_WIDTH) begin : g_full_range
    assign in_range = 1'b1;
  end else begin : g_part_range
    assign in_range = ({1'b0, rd_idx} < (ADDR_WIDTH+1)'(NUM_REGS));
  end

  // Select bypass/stored data; unreadable indices return zero and never look busy.
  always_comb begin
    readable = in_range && !(ZERO_REG && (rd_idx == ADDR_WIDTH'(ZERO_IDX)));
    fwd      = wr_valid && (wr_idx == rd_idx);
    rd_data  = '0;
    rd_busy  = 1'b0;
    if (readable) begin
      rd_data = fwd ? wr_data : regs[rd_idx];
      rd_busy = busy[rd_idx] && !fwd;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with write-through bypass on two read ports
// and a pending-write scoreboard (busy bit per register + in-flight count).
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned NUM_REGS   = 2**ADDR_WIDTH,
  parameter bit          ZERO_REG   = 1'b1
) (
  input  logic                  clock,
  input  logic                  ctrl_reset,
  input  logic                  ctrl_writeEnable,
  input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
  input  logic [DATA_WIDTH-1:0] data_writeReg,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
  input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
  output logic [DATA_WIDTH-1:0] data_readRegA,
  output logic [DATA_WIDTH-1:0] data_readRegB,
  input  logic                  ctrl_claim,
  input  logic [ADDR_WIDTH-1:0] ctrl_claimReg,
  output logic                  busy_readRegA,
  output logic                  busy_readRegB,
  output logic [ADDR_WIDTH:0]   pending_count,
  output logic                  pending_any
);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]                 busy_q, busy_d;
  logic [ADDR_WIDTH:0]                 pending_q, pending_d;

  logic wr_in_range, claim_in_range;
  logic wr_valid, claim_valid;
  logic cnt_inc, cnt_dec;

  if (NUM_REGS >= 2**ADDR_WIDTH) begin : g_full_range
    assign wr_in_range    = 1'b1;
    assign claim_in_range = 1'b1;
  end else begin : g_part_range
    assign wr_in_range    = ({1'b0, ctrl_writeReg} < (ADDR_WIDTH+1)'(NUM_REGS));
    assign claim_in_range = ({1'b0, ctrl_claimReg} < (ADDR_WIDTH+1)'(NUM_REGS));
  end

  // Qualify write/claim and compute next storage, busy bits and pending count.
  // The count is tracked incrementally from the busy transitions rather than
  // re-popcounting; claim-wins ordering is applied by setting after clearing.
  always_comb begin
    wr_valid    = ctrl_writeEnable && wr_in_range &&
                  !(ZERO_REG && (ctrl_writeReg == ADDR_WIDTH'(ZERO_IDX)));
    claim_valid = ctrl_claim && claim_in_range &&
                  !(ZERO_REG && (ctrl_claimReg == ADDR_WIDTH'(ZERO_IDX)));

    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_valid) begin
      regs_d[ctrl_writeReg] = data_writeReg;
      busy_d[ctrl_writeReg] = 1'b0;
    end
    if (claim_valid) begin
      busy_d[ctrl_claimReg] = 1'b1;
    end

    cnt_inc   = claim_valid && !busy_q[ctrl_claimReg];
    cnt_dec   = wr_valid && busy_q[ctrl_writeReg] &&
                !(claim_valid && (ctrl_claimReg == ctrl_writeReg));
    pending_d = pending_q + {{ADDR_WIDTH{1'b0}}, cnt_inc}
                          - {{ADDR_WIDTH{1'b0}}, cnt_dec};
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      regs_q    <= '0;
      busy_q    <= '0;
      pending_q <= '0;
    end else begin
      regs_q    <= regs_d;
      busy_q    <= busy_d;
      pending_q <= pending_d;
    end
  end

  assign pending_count = pending_q;
  assign pending_any   = (pending_q != '0);

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .ZERO_REG   (ZERO_REG)
  ) u_port_a (
    .rd_idx   (ctrl_readRegA),
    .regs     (regs_q),
    .busy     (busy_q),
    .wr_valid (wr_valid),
    .wr_idx   (ctrl_writeReg),
    .wr_data  (data_writeReg),
    .rd_data  (data_readRegA),
    .rd_busy  (busy_readRegA)
  );

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .ZERO_REG   (ZERO_REG)
  ) u_port_b (
    .rd_idx   (ctrl_readRegB),
    .regs     (regs_q),
    .busy     (busy_q),
    .wr_valid (wr_valid),
    .wr_idx   (ctrl_writeReg),
    .wr_data  (data_writeReg),
    .rd_data  (data_readRegB),
    .rd_busy  (busy_readRegB)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench: directed scenarios with literal expectations followed
// by randomized traffic, all checked against a behavioural register/busy model.
module tb_regfile_scoreboard;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NUM = 24;
  localparam bit ZR  = 1'b1;

  logic          clk;
  logic          rst;
  logic          we;
  logic [AW-1:0] wr;
  logic [DW-1:0] wd;
  logic [AW-1:0] ra, rb;
  logic [DW-1:0] rda, rdb;
  logic          cl;
  logic [AW-1:0] cr;
  logic          bza, bzb;
  logic [AW:0]   pend;
  logic          pany;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [DW-1:0] m_mem [32];
  bit            m_busy[32];

  regfile_scoreboard #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_REGS   (NUM),
    .ZERO_REG   (ZR)
  ) dut (
    .clock            (clk),
    .ctrl_reset       (rst),
    .ctrl_writeEnable (we),
    .ctrl_writeReg    (wr),
    .data_writeReg    (wd),
    .ctrl_readRegA    (ra),
    .ctrl_readRegB    (rb),
    .data_readRegA    (rda),
    .data_readRegB    (rdb),
    .ctrl_claim       (cl),
    .ctrl_claimReg    (cr),
    .busy_readRegA    (bza),
    .busy_readRegB    (bzb),
    .pending_count    (pend),
    .pending_any      (pany)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit writable(int i);
    return (i < NUM) && !(ZR && i == 0);
  endfunction

  function automatic logic [DW-1:0] exp_data(int idx);
    if (!writable(idx)) return '0;
    if (we && int'(wr) == idx) return wd;
    return m_mem[idx];
  endfunction

  function automatic bit exp_busy(int idx);
    return writable(idx) && m_busy[idx] && !(we && int'(wr) == idx);
  endfunction

  function automatic int exp_pending();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  // Effect of one rising edge: data write, write clears busy, claim then sets it
  task automatic model_update();
    if (rst) return;
    if (we && writable(int'(wr))) begin
      m_mem[int'(wr)]  = wd;
      m_busy[int'(wr)] = 1'b0;
    end
    if (cl && writable(int'(cr))) m_busy[int'(cr)] = 1'b1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_all();
    int ep;
    ep = exp_pending();
    chk("model_rdA",  rda, exp_data(int'(ra)));
    chk("model_rdB",  rdb, exp_data(int'(rb)));
    chk("model_bzA",  {31'd0, bza}, {31'd0, exp_busy(int'(ra))});
    chk("model_bzB",  {31'd0, bzb}, {31'd0, exp_busy(int'(rb))});
    chk("model_pend", {26'd0, pend}, 32'(ep));
    chk("model_any",  {31'd0, pany}, {31'd0, (ep != 0)});
  endtask

  task automatic drive(input logic w_e, input int w_r, input logic [DW-1:0] w_d,
                       input int r_a, input int r_b, input logic c_l, input int c_r);
    we = w_e; wr = AW'(w_r); wd = w_d;
    ra = AW'(r_a); rb = AW'(r_b);
    cl = c_l; cr = AW'(c_r);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 0, '0, 0, 0, 1'b0, 0);
    model_reset();
    @(negedge clk);

    // Reset: every index reads zero, nothing busy
    for (int i = 0; i < 32; i++) begin
      ra = AW'(i); rb = AW'(31 - i);
      #1;
      chk("rst_rdA", rda, 32'h0);
      chk("rst_rdB", rdb, 32'h0);
      check_all();
    end
    chk("rst_pend", {26'd0, pend}, 32'd0);
    chk("rst_any",  {31'd0, pany}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Register 0 is hardwired
    drive(1'b1, 0, 32'hDEADBEEF, 0, 0, 1'b0, 0); #1;
    chk("r0_bypass", rda, 32'h0); check_all(); tick();
    drive(1'b0, 0, '0, 0, 0, 1'b0, 0); #1;
    chk("r0_stored", rda, 32'h0); check_all(); tick();

    // Bypass on both ports, then stored value
    drive(1'b1, 5, 32'h12345678, 5, 5, 1'b0, 0); #1;
    chk("byp_A", rda, 32'h12345678); chk("byp_B", rdb, 32'h12345678);
    check_all(); tick();
    drive(1'b0, 0, '0, 5, 5, 1'b0, 0); #1;
    chk("hold_A", rda, 32'h12345678); chk("hold_B", rdb, 32'h12345678);
    check_all(); tick();

    // Claims 7 then 9, then clearing write to 7 forwarded with busy masked
    drive(1'b0, 0, '0, 7, 9, 1'b1, 7); #1;
    chk("claim_same_cycle_bz", {31'd0, bza}, 32'd0); check_all(); tick();
    drive(1'b0, 0, '0, 7, 9, 1'b1, 9); #1;
    chk("pend1", {26'd0, pend}, 32'd1); chk("bz7", {31'd0, bza}, 32'd1);
    check_all(); tick();
    drive(1'b1, 7, 32'hA5A5A5A5, 7, 9, 1'b0, 0); #1;
    chk("pend2", {26'd0, pend}, 32'd2); chk("fwd_bz7", {31'd0, bza}, 32'd0);
    chk("fwd_rd7", rda, 32'hA5A5A5A5); chk("bz9", {31'd0, bzb}, 32'd1);
    check_all(); tick();
    drive(1'b1, 9, 32'h99, 7, 9, 1'b0, 0); #1;
    chk("pend_after_clr7", {26'd0, pend}, 32'd1); check_all(); tick();

    // Claim and write to the same non-busy register: claim wins
    drive(1'b1, 3, 32'h11, 3, 3, 1'b1, 3); #1;
    chk("pend0", {26'd0, pend}, 32'd0); check_all(); tick();
    drive(1'b0, 0, '0, 3, 3, 1'b0, 0); #1;
    chk("cw_bz3", {31'd0, bza}, 32'd1); chk("cw_rd3", rda, 32'h11);
    chk("cw_pend", {26'd0, pend}, 32'd1); check_all(); tick();
    drive(1'b1, 3, 32'h22, 3, 3, 1'b0, 0); #1; check_all(); tick();

    // Double claim then single write: 1, 1, 0
    drive(1'b0, 0, '0, 3, 0, 1'b1, 3); #1; check_all(); tick();
    drive(1'b0, 0, '0, 3, 0, 1'b1, 3); #1;
    chk("dbl_pend_a", {26'd0, pend}, 32'd1); check_all(); tick();
    drive(1'b1, 3, 32'h33, 3, 0, 1'b0, 0); #1;
    chk("dbl_pend_b", {26'd0, pend}, 32'd1); check_all(); tick();
    drive(1'b0, 0, '0, 3, 0, 1'b0, 0); #1;
    chk("dbl_pend_c", {26'd0, pend}, 32'd0); check_all(); tick();

    // Out-of-range write and claim are ignored
    drive(1'b1, 30, 32'hCAFE, 30, 30, 1'b1, 28); #1;
    chk("oor_rd", rda, 32'h0); check_all(); tick();
    drive(1'b0, 0, '0, 30, 28, 1'b0, 0); #1;
    chk("oor_pend", {26'd0, pend}, 32'd0); check_all(); tick();

    // Asynchronous reset between edges
    drive(1'b1, 4, 32'hFF, 4, 6, 1'b0, 0); #1; check_all(); tick();
    drive(1'b0, 0, '0, 4, 6, 1'b1, 4); #1; check_all(); tick();
    drive(1'b0, 0, '0, 4, 6, 1'b1, 6); #1; check_all(); tick();
    drive(1'b0, 0, '0, 4, 6, 1'b0, 0); #1;
    chk("pre_rst_pend", {26'd0, pend}, 32'd2); chk("pre_rst_rd4", rda, 32'hFF);
    check_all();
    #1 rst = 1'b1; model_reset();
    #1;
    chk("arst_rd4", rda, 32'h0); chk("arst_bz4", {31'd0, bza}, 32'd0);
    chk("arst_pend", {26'd0, pend}, 32'd0); chk("arst_any", {31'd0, pany}, 32'd0);
    check_all();
    rst = 1'b0;
    drive(1'b0, 0, '0, 2, 4, 1'b1, 2); #1; check_all(); tick();
    drive(1'b0, 0, '0, 2, 4, 1'b0, 0); #1;
    chk("post_rst_pend", {26'd0, pend}, 32'd1); check_all(); tick();

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      int w_r, r_a, r_b, c_r;
      w_r = $urandom_range(0, 31);
      c_r = ($urandom_range(0, 3) == 0) ? w_r : $urandom_range(0, 31);
      r_a = ($urandom_range(0, 2) == 0) ? w_r : $urandom_range(0, 31);
      r_b = ($urandom_range(0, 2) == 0) ? c_r : $urandom_range(0, 31);
      drive(($urandom_range(0, 1) == 1), w_r, $urandom, r_a, r_b,
            ($urandom_range(0, 9) < 4), c_r);
      #1;
      check_all();
      if ($urandom_range(0, 149) == 0) begin
        #1 rst = 1'b1; model_reset();
        #1 check_all();
        rst = 1'b0;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
Parametrised successor to the processor's 32x32 register file: depth, width and the register-0 hardwiring are configurable. Adds same-cycle write-through bypass on both read ports. Adds a pending-write scoreboard (busy bit per register plus an in-flight counter), so the decode stage can stall on operands owned by multi-cycle mult/div operations. Sits between decode (reads, claims) and writeback (writes).

Parameters:
DATA_WIDTH, 32, bits per register
ADDR_WIDTH, 5, register index width
NUM_REGS, 2**ADDR_WIDTH, number of registers; must be <= 2**ADDR_WIDTH
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and claims; 0 = register 0 is ordinary

Ports:
clock  input  1  rising-edge clock
ctrl_reset  input  1  asynchronous, active-high reset
ctrl_writeEnable  input  1  writeback valid this cycle
ctrl_writeReg  input  ADDR_WIDTH  writeback destination index
data_writeReg  input  DATA_WIDTH  writeback data
ctrl_readRegA  input  ADDR_WIDTH  read port A index
ctrl_readRegB  input  ADDR_WIDTH  read port B index
data_readRegA  output  DATA_WIDTH  read port A data
data_readRegB  output  DATA_WIDTH  read port B data
ctrl_claim  input  1  issue of a multi-cycle op; marks destination busy
ctrl_claimReg  input  ADDR_WIDTH  destination being claimed
busy_readRegA  output  1  port A operand has a pending write
busy_readRegB  output  1  port B operand has a pending write
pending_count  output  ADDR_WIDTH+1  number of busy registers
pending_any  output  1  pending_count != 0

Behaviour:
- Reset (async, any time, including mid-operation):
  - all registers = 0, all busy bits = 0, pending_count = 0.
  - Outputs follow combinationally: read data = 0 unless bypassing, busy = 0.
- Write:
  - On the rising clock edge with ctrl_writeEnable=1, reg[ctrl_writeReg] <= data_writeReg.
  - The write is ignored if the index >= NUM_REGS, or if ZERO_REG=1 and the index = 0.
- Read:
  - Combinational, zero latency.
  - Bypass: if ctrl_writeEnable=1, ctrl_writeReg equals the read index, and that index is writable, the port returns data_writeReg in the same cycle.
  - Otherwise the port returns the stored value.
  - An index >= NUM_REGS reads 0. Register 0 reads 0 when ZERO_REG=1, including during a bypass attempt.
  - Ports A and B are fully independent; both may address the same register.
- Scoreboard, updated on the rising edge:
  - ctrl_claim=1 with a valid claimable index sets busy[ctrl_claimReg].
  - A valid write clears busy[ctrl_writeReg].
  - Claim and write to the same index in one cycle: claim wins, busy stays 1 (a new producer is in flight). The data write still occurs.
  - Claim of an already-busy register: busy stays 1; pending_count unchanged.
  - Write to a non-busy register: no scoreboard change.
  - Claim of register 0 (ZERO_REG=1) or of an out-of-range index is ignored.
- Busy outputs:
  - busy_readRegX = busy[index] AND NOT (same-cycle valid write to that index).
  - The forwarded write satisfies the dependency in the current cycle.
  - A same-cycle claim does not raise busy until the next cycle.
- pending_count:
  - Registered; equals popcount of the busy bits at all times.
  - Per cycle it changes by +1 (new claim only), -1 (clearing write only), or 0 (both, or neither effective).
  - Can never exceed NUM_REGS, so no saturation logic is needed.
- No handshake or backpressure: the caller gates issue using the busy outputs.

Decomposition:
- Shared processor package holds: DATA_WIDTH/ADDR_WIDTH defaults, the reg_idx_t and word_t typedefs, and the ZERO_IDX constant.
- One natural sub-module: regfile_read_port (index decode, out-of-range/zero masking, bypass mux, busy masking).
  - Instantiated twice.
  - Storage, scoreboard and counter stay in the top.

Test Plan:
- Reset then read all indices -> every data_read = 0, busy = 0, pending_count = 0; writing reg0=0xDEADBEEF (ZERO_REG=1) then reading A=0 -> 0x00000000.
- Write reg5=0x12345678 with A=5, B=5 in the same cycle -> both ports show 0x12345678 that cycle (bypass) and hold it after the edge with writeEnable=0.
- Claim reg7, then reg9 on consecutive cycles -> pending_count goes 1, 2; A=7 busy=1. A write to reg7=0xA5A5A5A5 with A=7 -> busy_readRegA=0 and data 0xA5A5A5A5 in that cycle; pending_count=1 after the edge.
- Claim reg3 and write reg3=0x11 in the same cycle (reg3 not busy) -> after the edge busy[3]=1, reg3=0x11, pending_count=1.
- Claim reg3 twice, then write once -> pending_count goes 1, 1, 0.
- Assert ctrl_reset asynchronously between edges while pending_count=2 and reg4=0xFF -> outputs go to 0 immediately without a clock edge; after release, claims count from 0.
